seq_divider: RTL and testbench

- Multi-cycle restoring divider: the inverse-operation companion to the team's radix-4 Booth multiplier datapath.
- Takes an 8-bit dividend and divisor through a start/done handshake and returns quotient and remainder, signed or unsigned.
- Sits beside the multiplier in the arithmetic unit.
- Retires one quotient bit per cycle using a shift/trial-subtract datapath.

---
 rtl/divider_pkg.sv | 11 +
 rtl/div_step.sv | 16 +
 rtl/seq_divider.sv | 82 ++++++++
 tb/tb_seq_divider.sv | 121 ++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding, default width and counter sizing for the sequential divider
package divider_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring iteration (shift in a dividend bit, trial-subtract)
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] pr,
  input  logic           bit_in,
  input  logic [WIDTH:0] dmag,
  output logic [WIDTH:0] pr_nxt,
  output logic           q_bit
);
  logic [WIDTH+1:0] sh, trial;
  assign sh     = {pr, bit_in};
  assign trial  = sh - {1'b0, dmag};
  assign q_bit  = ~trial[WIDTH+1];
  assign pr_nxt = q_bit ? trial[WIDTH:0] : sh[WIDTH:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, signed/unsigned, one quotient bit per cycle
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = clog2(WIDTH);
  state_e           state, nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   pr, dmag, pr_n;
  logic [WIDTH-1:0] sr, dvd, a_mag, b_mag;
  logic             sgn_q, sgn_r, dz, a_neg, b_neg, qb;
  assign a_neg = signed_mode & dividend[WIDTH-1];
  assign b_neg = signed_mode & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;
  assign busy  = state != IDLE;
  div_step #(.WIDTH(WIDTH)) u_step (
    .pr(pr), .bit_in(sr[WIDTH-1]), .dmag(dmag), .pr_nxt(pr_n), .q_bit(qb)
  );
  always_comb begin
    nxt = state == IDLE ? (start ? RUN : IDLE) :
          state == RUN  ? (cnt == '0 ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pr          <= '0;
      dmag        <= '0;
      sr          <= '0;
      dvd         <= '0;
      sgn_q       <= 1'b0;
      sgn_r       <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt         <= CW'(WIDTH - 1);
          pr          <= '0;
          dmag        <= {1'b0, b_mag};
          sr          <= a_mag;
          dvd         <= dividend;
          sgn_q       <= a_neg ^ b_neg;
          sgn_r       <= a_neg;
          dz          <= divisor == '0;
          div_by_zero <= 1'b0;
        end
        RUN: begin
          pr  <= pr_n;
          sr  <= {sr[WIDTH-2:0], qb};
          cnt <= cnt - 1'b1;
        end
        default: begin
          // a zero divisor bypasses sign fixing and reports the raw dividend
          quotient    <= dz ? '1 : (sgn_q ? -sr : sr);
          remainder   <= dz ? dvd : (sgn_r ? -pr[WIDTH-1:0] : pr[WIDTH-1:0]);
          div_by_zero <= dz;
          done        <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed scoreboard bench for seq_divider (results, latency, handshake, reset)
module tb_seq_divider;
  logic       clk = 0, rst = 0, start = 0, signed_mode = 0;
  logic [7:0] dividend = 0, divisor = 0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;
  int         tests = 0, errs = 0, cyc = 0;
  typedef struct {logic [7:0] q; logic [7:0] r; logic z; int c;} exp_t;
  exp_t sb[$];

  seq_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) check("spurious_done", 32'(done), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.z));
        check("latency", 32'(cyc), 32'(e.c));
        check("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  // drive one request at a negedge; expected done lands WIDTH+2 edges later
  task automatic go(input logic sm, input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] q, input logic [7:0] r, input logic z, input bit push);
    @(negedge clk);
    start = 1; signed_mode = sm; dividend = a; divisor = b;
    if (push) sb.push_back('{q: q, r: r, z: z, c: cyc + 10});
    @(negedge clk);
    start = 0; dividend = 8'hxx; divisor = 8'hxx;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int bc;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    rst = 1;
    go(0, 8'd100, 8'd7, 8'h0E, 8'h02, 0, 1);
    bc = 32'(busy);
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (!done) bc += 32'(busy);
    end
    check("busy_cycles", 32'(bc), 32'd9);
    drain();
    go(1, 8'h9C, 8'h07, 8'hF2, 8'hFE, 0, 1);
    drain();
    go(1, 8'd100, 8'hF9, 8'hF2, 8'h02, 0, 1);
    drain();
    go(0, 8'h55, 8'h00, 8'hFF, 8'h55, 1, 1);
    drain();
    @(negedge clk);
    check("dz_hold", 32'(div_by_zero), 32'd1);
    go(0, 8'd9, 8'd3, 8'd3, 8'd0, 0, 1);
    drain();
    go(1, 8'h80, 8'hFF, 8'h80, 8'h00, 0, 1);
    drain();
    go(0, 8'hFF, 8'h01, 8'hFF, 8'h00, 0, 1);
    drain();
    go(1, 8'h80, 8'h03, 8'hD6, 8'hFE, 0, 1);
    drain();
    go(0, 8'd200, 8'd3, 8'd66, 8'd2, 0, 1);
    repeat (3) @(negedge clk);
    start = 1; signed_mode = 0; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    check("handshake_done_seen", 32'(done), 32'd1);
    start = 1; signed_mode = 0; dividend = 8'd50; divisor = 8'd5;
    sb.push_back('{q: 8'd10, r: 8'd0, z: 1'b0, c: cyc + 10});
    @(negedge clk);
    start = 0;
    drain();
    repeat (12) @(negedge clk);
    go(0, 8'd77, 8'd7, 8'd0, 8'd0, 0, 0);
    repeat (4) @(negedge clk);
    #2 rst = 0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_q", 32'(quotient), 32'd0);
    check("midrst_r", 32'(remainder), 32'd0);
    @(negedge clk);
    rst = 1;
    repeat (15) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);
    go(0, 8'd81, 8'd9, 8'd9, 8'd0, 0, 1);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
